mem_reset_seq: RTL and testbench



---
 rtl/mem_clk_pkg.sv | 30 +++
 rtl/sync_2ff.sv | 22 ++
 rtl/mem_reset_seq.sv | 141 ++++++++++++++
 tb/tb_mem_reset_seq.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_clk_pkg.sv
// Shared definitions for the memory-clock reset sequencer: state encodings,
// default cycle counts and the loss-statistic width.
package mem_clk_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABLE    = 3'd1,
        RST_HOLD  = 3'd2,
        INIT_WAIT = 3'd3,
        READY     = 3'd4
    } seq_state_t;

    localparam int DEF_LOCK_STABLE     = 1024;
    localparam int DEF_RST_HOLD        = 16;
    localparam int DEF_INIT_WAIT_200US = 40000;

    localparam int LOSS_CNT_W = 8;

    // Saturating increment for the lock-loss statistic
    function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] value);
        logic [LOSS_CNT_W-1:0] result;
        if (value == {LOSS_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(LOSS_CNT_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser with synchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mem_reset_seq.sv
// DRAM-controller reset sequencer: qualifies the memory PLL lock, holds and
// releases mem_rst, waits the power-up interval and tracks lock-loss events.
module mem_reset_seq
    import mem_clk_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE,
    parameter int RST_HOLD_CYCLES    = DEF_RST_HOLD,
    parameter int INIT_WAIT_CYCLES   = DEF_INIT_WAIT_200US
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pll_lock,
    input  logic                  clr_stat,
    output logic                  mem_rst,
    output logic                  init_ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
    output logic [2:0]            seq_state
);

    localparam int MAX_AB  = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
    localparam int MAX_CYC = (MAX_AB > INIT_WAIT_CYCLES) ? MAX_AB : INIT_WAIT_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LAST   = CNT_W'(INIT_WAIT_CYCLES - 1);

    seq_state_t       state_r;
    seq_state_t       next_state;
    logic [CNT_W-1:0] cnt_r;
    logic             lock_s;
    logic             lock_prev_r;
    logic             loss_evt;
    logic             counting;

    sync_2ff u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_lock),
        .q   (lock_s)
    );

    assign seq_state = state_r;

    // Next-state selection; a dropped lock beats every other transition
    always_comb begin
        next_state = state_r;
        counting   = 1'b0;
        loss_evt   = lock_prev_r && !lock_s && (state_r != WAIT_LOCK);
        case (state_r)
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = STABLE;
                end else begin
                    next_state = WAIT_LOCK;
                end
            end
            STABLE: begin
                counting = 1'b1;
                if (cnt_r == STABLE_LAST) begin
                    next_state = RST_HOLD;
                end else begin
                    next_state = STABLE;
                end
            end
            RST_HOLD: begin
                counting = 1'b1;
                if (cnt_r == HOLD_LAST) begin
                    next_state = INIT_WAIT;
                end else begin
                    next_state = RST_HOLD;
                end
            end
            INIT_WAIT: begin
                counting = 1'b1;
                if (cnt_r == WAIT_LAST) begin
                    next_state = READY;
                end else begin
                    next_state = INIT_WAIT;
                end
            end
            READY: begin
                next_state = READY;
            end
            default: begin
                next_state = WAIT_LOCK;
            end
        endcase
        if (state_r != WAIT_LOCK && !lock_s) begin
            next_state = WAIT_LOCK;
        end else begin
            next_state = next_state;
        end
    end

    // State, counter and registered reset/ready outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= WAIT_LOCK;
            cnt_r       <= '0;
            lock_prev_r <= 1'b0;
            mem_rst     <= 1'b1;
            init_ready  <= 1'b0;
        end else begin
            state_r     <= next_state;
            lock_prev_r <= lock_s;
            if (next_state != state_r) begin
                cnt_r <= '0;
            end else if (counting) begin
                cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                cnt_r <= '0;
            end
            mem_rst    <= !((next_state == INIT_WAIT) || (next_state == READY));
            init_ready <= (next_state == READY);
        end
    end

    // Sticky loss statistics; a loss event takes priority over a clear
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
        end else if (loss_evt) begin
            lock_lost <= 1'b1;
            if (clr_stat) begin
                lock_loss_cnt <= LOSS_CNT_W'(1);
            end else begin
                lock_loss_cnt <= sat_inc(lock_loss_cnt);
            end
        end else if (clr_stat) begin
            lock_lost     <= 1'b0;
            lock_loss_cnt <= '0;
        end else begin
            lock_lost     <= lock_lost;
            lock_loss_cnt <= lock_loss_cnt;
        end
    end

endmodule

// File: tb/tb_mem_reset_seq.sv
// Directed bench for mem_reset_seq with short cycle parameters (4/3/10).
module tb_mem_reset_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_lock;
    logic       clr_stat;
    logic       mem_rst;
    logic       init_ready;
    logic       lock_lost;
    logic [7:0] lock_loss_cnt;
    logic [2:0] seq_state;

    int vectors    = 0;
    int miscompares = 0;

    mem_reset_seq #(
        .LOCK_STABLE_CYCLES (4),
        .RST_HOLD_CYCLES    (3),
        .INIT_WAIT_CYCLES   (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_lock      (pll_lock),
        .clr_stat      (clr_stat),
        .mem_rst       (mem_rst),
        .init_ready    (init_ready),
        .lock_lost     (lock_lost),
        .lock_loss_cnt (lock_loss_cnt),
        .seq_state     (seq_state)
    );

    always #5 clk = ~clk;

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at the negedge just after pll_lock has been raised (edge e0 next)
    task automatic seq_timing(input string tag);
        ticks(1);
        chk({tag, " e0 state"}, 16'(seq_state), 16'd0);
        ticks(2);
        chk({tag, " e2 state"}, 16'(seq_state), 16'd1);
        chk({tag, " e2 mem_rst"}, 16'(mem_rst), 16'd1);
        ticks(6);
        chk({tag, " e8 mem_rst"}, 16'(mem_rst), 16'd1);
        chk({tag, " e8 state"}, 16'(seq_state), 16'd2);
        ticks(1);
        chk({tag, " e9 mem_rst"}, 16'(mem_rst), 16'd0);
        chk({tag, " e9 state"}, 16'(seq_state), 16'd3);
        ticks(9);
        chk({tag, " e18 init_ready"}, 16'(init_ready), 16'd0);
        ticks(1);
        chk({tag, " e19 init_ready"}, 16'(init_ready), 16'd1);
        chk({tag, " e19 state"}, 16'(seq_state), 16'd4);
        chk({tag, " e19 mem_rst"}, 16'(mem_rst), 16'd0);
    endtask

    initial begin
        rst      = 1'b1;
        pll_lock = 1'b0;
        clr_stat = 1'b0;
        @(negedge clk);
        ticks(2);
        chk("reset mem_rst", 16'(mem_rst), 16'd1);
        chk("reset init_ready", 16'(init_ready), 16'd0);
        chk("reset lock_lost", 16'(lock_lost), 16'd0);
        chk("reset loss_cnt", 16'(lock_loss_cnt), 16'd0);
        chk("reset state", 16'(seq_state), 16'd0);

        // clean power-up
        rst      = 1'b0;
        pll_lock = 1'b1;
        seq_timing("powerup");
        chk("powerup loss_cnt", 16'(lock_loss_cnt), 16'd0);

        // lock drop in READY, then re-lock
        pll_lock = 1'b0;
        ticks(2);
        chk("drop k+1 state", 16'(seq_state), 16'd4);
        chk("drop k+1 mem_rst", 16'(mem_rst), 16'd0);
        ticks(1);
        chk("drop k+2 state", 16'(seq_state), 16'd0);
        chk("drop k+2 mem_rst", 16'(mem_rst), 16'd1);
        chk("drop k+2 init_ready", 16'(init_ready), 16'd0);
        chk("drop k+2 lock_lost", 16'(lock_lost), 16'd1);
        chk("drop k+2 loss_cnt", 16'(lock_loss_cnt), 16'd1);
        pll_lock = 1'b1;
        seq_timing("relock");

        // one-cycle glitch while STABLE cnt==2
        rst      = 1'b1;
        pll_lock = 1'b0;
        ticks(2);
        rst      = 1'b0;
        pll_lock = 1'b1;
        ticks(3);
        chk("glitch e2 state", 16'(seq_state), 16'd1);
        pll_lock = 1'b0;
        ticks(1);
        pll_lock = 1'b1;
        ticks(1);
        chk("glitch e4 state", 16'(seq_state), 16'd1);
        ticks(1);
        chk("glitch e5 state", 16'(seq_state), 16'd0);
        chk("glitch e5 loss_cnt", 16'(lock_loss_cnt), 16'd1);
        chk("glitch e5 lock_lost", 16'(lock_lost), 16'd1);
        ticks(1);
        chk("glitch e6 state", 16'(seq_state), 16'd1);
        ticks(6);
        chk("glitch e12 mem_rst", 16'(mem_rst), 16'd1);
        chk("glitch e12 state", 16'(seq_state), 16'd2);
        ticks(1);
        chk("glitch e13 mem_rst", 16'(mem_rst), 16'd0);

        // 260 drops saturate the counter
        rst      = 1'b1;
        pll_lock = 1'b0;
        ticks(2);
        rst = 1'b0;
        for (int i = 0; i < 260; i++) begin
            pll_lock = 1'b1;
            ticks(3);
            pll_lock = 1'b0;
            ticks(3);
        end
        chk("sat loss_cnt", 16'(lock_loss_cnt), 16'd255);
        chk("sat lock_lost", 16'(lock_lost), 16'd1);

        clr_stat = 1'b1;
        ticks(1);
        clr_stat = 1'b0;
        chk("clr lock_lost", 16'(lock_lost), 16'd0);
        chk("clr loss_cnt", 16'(lock_loss_cnt), 16'd0);

        for (int i = 0; i < 2; i++) begin
            pll_lock = 1'b1;
            ticks(3);
            pll_lock = 1'b0;
            ticks(3);
        end
        chk("two drops loss_cnt", 16'(lock_loss_cnt), 16'd2);
        pll_lock = 1'b1;
        ticks(3);
        pll_lock = 1'b0;
        ticks(2);
        clr_stat = 1'b1;
        ticks(1);
        clr_stat = 1'b0;
        chk("clr+drop loss_cnt", 16'(lock_loss_cnt), 16'd1);
        chk("clr+drop lock_lost", 16'(lock_lost), 16'd1);
        chk("clr+drop state", 16'(seq_state), 16'd0);

        // rst during INIT_WAIT at cnt==5
        pll_lock = 1'b1;
        ticks(15);
        chk("midrst e14 state", 16'(seq_state), 16'd3);
        chk("midrst e14 mem_rst", 16'(mem_rst), 16'd0);
        rst = 1'b1;
        ticks(1);
        rst = 1'b0;
        chk("midrst mem_rst", 16'(mem_rst), 16'd1);
        chk("midrst init_ready", 16'(init_ready), 16'd0);
        chk("midrst state", 16'(seq_state), 16'd0);
        chk("midrst lock_lost", 16'(lock_lost), 16'd0);
        chk("midrst loss_cnt", 16'(lock_loss_cnt), 16'd0);
        seq_timing("rerun");

        // lock never arrives
        rst      = 1'b1;
        pll_lock = 1'b0;
        ticks(1);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            ticks(10);
            chk("idle state", 16'(seq_state), 16'd0);
            chk("idle mem_rst", 16'(mem_rst), 16'd1);
            chk("idle init_ready", 16'(init_ready), 16'd0);
        end
        chk("idle loss_cnt", 16'(lock_loss_cnt), 16'd0);
        chk("idle lock_lost", 16'(lock_lost), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
